// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-outstanding-request memory access controller (load/store with fixed wait states)
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_op, req_addr, req_wdata latched on handshake
//   resp_valid                    one-cycle completion pulse; resp_rdata/resp_err hold until next completion
//   mem_en/mem_we                 one-cycle access strobe and write select
//   mem_addr/mem_wdata/mem_rdata  word-aligned address, write data, read data
//   busy                          controller not idle
// Optional macro MISALIGN_CHECK_EN: reject loads/stores whose addr[1:0] != 0 with resp_err.
package operationList;
    localparam logic [3:0] LOAD  = 4'h1;
    localparam logic [3:0] STORE = 4'h2;
endpackage

module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    import operationList::*;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nx;
    logic [3:0] op_q, cnt;
    logic       hs, legal, reject, last_wait;

    assign hs        = req_valid && req_ready;
    assign legal     = req_op == LOAD || req_op == STORE;
    assign last_wait = state == WAIT && cnt == 4'd0;

`ifdef MISALIGN_CHECK_EN
    assign reject = !legal || req_addr[1:0] != 2'b00;
`else
    logic unused_lo;
    assign unused_lo = ^req_addr[1:0];
    assign reject    = !legal;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    // Rejected requests bypass the memory entirely and complete next cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = hs ? (reject ? RESP : ISSUE) : IDLE;
            ISSUE: state_nx = WAIT;
            WAIT:  state_nx = cnt == 4'd0 ? RESP : WAIT;
            RESP:  state_nx = IDLE;
        endcase
    end

    // req_ready is gated by reset_n so it reads low while reset is held.
    always_comb begin
        req_ready  = reset_n && state == IDLE;
        busy       = state != IDLE;
        mem_en     = state == ISSUE;
        mem_we     = state == ISSUE && op_q == STORE;
        resp_valid = state == RESP;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            op_q       <= 4'd0;
            cnt        <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (hs) begin
                op_q      <= req_op;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= req_wdata;
            end
            if (hs && reject) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b1;
            end
            if (state == ISSUE)
                cnt <= 4'(WAIT_CYCLES);
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            // mem_rdata is valid in the final wait cycle; capture on its closing edge.
            if (last_wait) begin
                resp_rdata <= op_q == LOAD ? mem_rdata : 32'd0;
                resp_err   <= 1'b0;
            end
        end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench for mem_access_ctrl against a cycle-timeline model
module tb_mem_access_ctrl;
    import operationList::*;

    localparam int W  = 2;
    localparam int AW = 32;

    logic          clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0;
    logic [3:0]    req_op = 4'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0, mem_rdata = 32'd0;
    logic          req_ready, resp_valid, resp_err, mem_en, mem_we, busy;
    logic [31:0]   resp_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    int            vecs = 0, errs = 0, cyc = 0;

    mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // One transaction: handshake at the first ready negedge (cycle T), then walk the
    // expected timeline T+1..T+len and the following idle cycle.
    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input bit rnd, output int t_hs);
        int n, len;
        logic err;
        logic [31:0] exp_rd, drv;
        logic [4:0] exp;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL ready_wait got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        mem_rdata = rnd ? $urandom : rd;
        t_hs = cyc;
        err = !(op == LOAD || op == STORE);
`ifdef MISALIGN_CHECK_EN
        err = err || addr[1:0] != 2'b00;
`endif
        len = err ? 1 : W + 3;
        exp_rd = 32'd0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, !err && k == 1, !err && k == 1 && op == STORE, k == len};
            vecs++;
            if ({busy, req_ready, mem_en, mem_we, resp_valid} !== exp) begin
                errs++;
                $display("FAIL ctrl op=%h k=%0d got=%b want=%b (busy,ready,en,we,rv)", op, k,
                         {busy, req_ready, mem_en, mem_we, resp_valid}, exp);
            end
            if (!err) begin
                vecs++;
                if (mem_addr !== {addr[31:2], 2'b00} || mem_wdata !== wd) begin
                    errs++;
                    $display("FAIL mem_bus k=%0d got=%h/%h want=%h/%h", k, mem_addr, mem_wdata,
                             {addr[31:2], 2'b00}, wd);
                end
            end
            if (k == len) begin
                vecs++;
                if (resp_rdata !== exp_rd || resp_err !== err) begin
                    errs++;
                    $display("FAIL resp op=%h got=%h/%b want=%h/%b", op, resp_rdata, resp_err, exp_rd, err);
                end
                req_valid = 1'b0;
            end else begin
                // requester noise while busy must be ignored
                req_valid = 1'($urandom); req_op = 4'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            drv = rnd ? $urandom : rd;
            mem_rdata = drv;
            if (!err && op == LOAD && k == W + 2) exp_rd = drv;
        end
        @(negedge clk);
        vecs++;
        if ({busy, req_ready, resp_valid} !== 3'b010 || resp_rdata !== exp_rd || resp_err !== err) begin
            errs++;
            $display("FAIL idle_hold got=%b %h %b want=010 %h %b", {busy, req_ready, resp_valid},
                     resp_rdata, resp_err, exp_rd, err);
        end
    endtask

    task automatic test_reset;
        #1;
        vecs++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
            errs++;
            $display("FAIL reset_state got ready=%b rv=%b err=%b rd=%h en=%b we=%b a=%h wd=%h busy=%b",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        vecs++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_release got ready=%b busy=%b want 1/0", req_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_load;
        int t;
        do_txn(LOAD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, t);
    endtask

    task automatic test_store;
        int t;
        do_txn(STORE, 32'h40, 32'h12345678, 32'hA5A5A5A5, 1'b0, t);
    endtask

    task automatic test_misaligned;
        int t;
        do_txn(LOAD, 32'h102, 32'h0, 32'hCAFEF00D, 1'b0, t);
        do_txn(STORE, 32'h203, 32'h55AA55AA, 32'h0, 1'b1, t);
    endtask

    task automatic test_illegal_op;
        int t;
        do_txn(4'hF, 32'h80, 32'h11111111, 32'h22222222, 1'b0, t);
        do_txn(4'h0, 32'h84, 32'h33333333, 32'h44444444, 1'b0, t);
    endtask

    task automatic test_back_to_back;
        int t1, t2, t3;
        do_txn(LOAD, $urandom, $urandom, 32'h0, 1'b1, t1);
        do_txn(STORE, $urandom, $urandom, 32'h0, 1'b1, t2);
        do_txn(LOAD, $urandom, $urandom, 32'h0, 1'b1, t3);
        vecs++;
        if (t2 - t1 != W + 4 || t3 - t2 != W + 4) begin
            errs++;
            $display("FAIL throughput got=%0d,%0d want=%0d", t2 - t1, t3 - t2, W + 4);
        end
    endtask

    task automatic test_random;
        int t, r;
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 3);
            op = r == 0 ? LOAD : r == 1 ? STORE : r == 2 ? 4'($urandom) : LOAD;
            do_txn(op, $urandom, $urandom, 32'h0, 1'b1, t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Reset mid-operation: once in ISSUE (mem_en must drop without a clock), once in WAIT.
    task automatic test_reset_mid(input int at_k);
        int t;
        req_valid = 1'b1; req_op = LOAD; req_addr = 32'h300; req_wdata = 32'h0;
        mem_rdata = $urandom;
        for (int k = 1; k <= at_k; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        vecs++;
        if (busy !== 1'b1 || mem_en !== (at_k == 1)) begin
            errs++;
            $display("FAIL pre_reset k=%0d got busy=%b en=%b", at_k, busy, mem_en);
        end
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({mem_en, mem_we, busy, resp_valid, req_ready} !== 5'b0) begin
            errs++;
            $display("FAIL async_reset k=%0d got=%b want=00000", at_k, {mem_en, mem_we, busy, resp_valid, req_ready});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            vecs++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL abandoned k=%0d got rv=%b busy=%b want 0/0", k, resp_valid, busy);
            end
        end
        do_txn(LOAD, 32'h400, 32'h0, 32'h0BADC0DE, 1'b0, t);
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_misaligned;
        test_illegal_op;
        test_back_to_back;
        test_reset_mid(1);
        test_reset_mid(3);
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2: extra memory wait states, legal range 0-15.
REQ-002 SHALL provide parameter ADDR_W, default 32: address width.
REQ-003 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL provide port req_valid, input, 1: requester presents an operation.
REQ-006 SHALL provide port req_ready, output, 1: controller accepts an operation this cycle.
REQ-007 SHALL provide port req_op, input, 4: operation code; package operationList encodings load and store.
REQ-008 SHALL provide port req_addr, input, ADDR_W: byte address.
REQ-009 SHALL provide port req_wdata, input, 32: store data.
REQ-010 SHALL provide port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL provide port resp_rdata, output, 32: load result.
REQ-012 SHALL provide port resp_err, output, 1: completion carried an error; qualified by resp_valid.
REQ-013 SHALL provide ports mem_en, output, 1, and mem_we, output, 1: memory access strobe and write select.
REQ-014 SHALL provide ports mem_addr, output, ADDR_W; mem_wdata, output, 32; mem_rdata, input, 32: memory address, write data and read data.
REQ-015 SHALL provide port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 SHALL drive req_ready high only in IDLE; handshake = req_valid && req_ready; req_valid held while req_ready is low SHALL have no effect.
REQ-018 SHALL latch req_op, req_addr and req_wdata on handshake; later changes on these inputs SHALL be ignored until the next handshake.
REQ-019 Handshake in cycle T with op load or store SHALL move IDLE->ISSUE; ISSUE (cycle T+1) SHALL assert mem_en=1 for exactly one cycle, with mem_we=1 for store and 0 for load.
REQ-020 mem_en and mem_we SHALL be 0 in every state except ISSUE; mem_addr and mem_wdata SHALL hold the latched values from ISSUE until the next handshake.
REQ-021 mem_addr SHALL be {addr[ADDR_W-1:2],2'b00}.
REQ-022 WAIT SHALL last exactly WAIT_CYCLES+1 cycles, timed by a 4-bit down-counter loaded on ISSUE; mem_rdata is valid in the last WAIT cycle and SHALL be captured at its closing edge for loads.
REQ-023 RESP SHALL occur in cycle T+3+WAIT_CYCLES with resp_valid=1 for exactly one cycle, then return to IDLE, giving one request per WAIT_CYCLES+4 cycles.
REQ-024 On a load, resp_rdata SHALL carry the captured word; on a store, resp_rdata SHALL be 0; in both cases resp_err=0.
REQ-025 A req_op other than load or store SHALL be accepted, SHALL go IDLE->RESP at T+1 with resp_err=1 and resp_rdata=0, and SHALL produce no mem_en pulse.
REQ-026 resp_rdata and resp_err SHALL hold their values after the pulse until the next RESP.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, WAIT counter 0, and outputs req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-028 req_ready SHALL rise in the first cycle after reset_n deasserts.
REQ-029 Reset asserted mid-operation SHALL abandon the operation: no resp_valid for it, and mem_en SHALL drop asynchronously.

Configuration
REQ-030 Macro MISALIGN_CHECK_EN, when defined: a load or store with latched addr[1:0]!=0 SHALL skip ISSUE/WAIT, go IDLE->RESP at T+1 with resp_err=1 and resp_rdata=0, and SHALL produce no mem_en pulse.
REQ-031 Without MISALIGN_CHECK_EN: addr[1:0] SHALL be ignored, the access SHALL proceed at the aligned word per REQ-021, and resp_err SHALL never be set for alignment.

Verification
REQ-032 Load, WAIT_CYCLES=2: handshake at cycle 10, addr 0x100, mem_rdata 0xDEADBEEF -> mem_en=1, mem_we=0 at cycle 11; resp_valid=1 at cycle 15 with rdata 0xDEADBEEF, err=0.
REQ-033 Store, WAIT_CYCLES=0: addr 0x40, wdata 0x12345678 -> mem_we=1, mem_addr 0x40 at T+1; resp_valid at T+3 with rdata 0; req_ready high again at T+4.
REQ-034 Misaligned load at addr 0x102 -> with MISALIGN_CHECK_EN, resp_err=1 at T+1 and no mem_en; without it, mem_addr=0x100 and normal completion.
REQ-035 Illegal op 4'hF -> resp_valid=1, resp_err=1 at T+1; mem_en stays 0.
REQ-036 reset_n low during WAIT -> mem_en=0 and busy=0 immediately, no resp_valid; a new load completes normally after release.
